fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a simple in-order core. A four-state FSM
// walks IDLE -> FETCH -> ISSUE: it requests the word at pc from instruction
// memory, waits for the response, holds it for decode, then steps pc either
// sequentially or to a redirect target. A misaligned redirect target latches
// a sticky fault and parks the unit in HALT until reset.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   imem_req     instruction-memory read request (FETCH only)
//   imem_addr    instruction-memory byte address (always pc)
//   imem_ready   imem_rdata is valid this cycle
//   imem_rdata   fetched instruction word
//   stall        downstream not ready, hold the issued instruction
//   redirect     take target instead of pc+4
//   target       redirect destination address
//   pc           address of the instruction currently held
//   pc_plus4     pc + 4, for link-register writeback
//   instr        held instruction word
//   instr_valid  instr/pc valid for decode this cycle (ISSUE only)
//   opcode       instr[6:0]
//   fun3         instr[14:12]
//   fun7         instr[30]
//   misaligned   sticky misaligned-target fault flag
//   instret      count of issued instructions
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  fun3,
  output logic        fun7,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_r;
  logic [31:0] pc_next;
  logic [31:0] instr_r;
  logic [31:0] instr_next;
  logic [31:0] instret_r;
  logic [31:0] instret_next;
  logic        mis_r;
  logic        mis_next;
  logic [31:0] seq_pc;
  logic        tgt_aligned;

  // Sequential successor; plain 32-bit add wraps naturally at the top.
  assign seq_pc      = pc_r + 32'd4;
  assign tgt_aligned = (target[1:0] == 2'b00);

  // State register. Reset clears everything, including a response that
  // arrives in the same cycle as rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      instret_r <= 32'h0000_0000;
      mis_r     <= 1'b0;
    end else begin
      state     <= state_next;
      pc_r      <= pc_next;
      instr_r   <= instr_next;
      instret_r <= instret_next;
      mis_r     <= mis_next;
    end
  end

  // Next-state logic. Everything holds unless a state explicitly updates it,
  // so stall/redirect are naturally ignored outside ISSUE and the memory
  // response outside FETCH.
  always_comb begin
    state_next   = state;
    pc_next      = pc_r;
    instr_next   = instr_r;
    instret_next = instret_r;
    mis_next     = mis_r;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (!redirect) begin
            pc_next      = seq_pc;
            instret_next = instret_r + 32'd1;
            state_next   = FETCH;
          end else if (tgt_aligned) begin
            pc_next      = target;
            instret_next = instret_r + 32'd1;
            state_next   = FETCH;
          end else begin
            // Faulting redirect does not retire: pc and instret stay put so
            // the offending instruction can be identified afterwards.
            mis_next   = 1'b1;
            state_next = HALT;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc_r;
  assign instr_valid = (state == ISSUE);
  assign pc          = pc_r;
  assign pc_plus4    = seq_pc;
  assign instr       = instr_r;
  assign opcode      = instr_r[6:0];
  assign fun3        = instr_r[14:12];
  assign fun7        = instr_r[30];
  assign misaligned  = mis_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic        fun7;
  logic        misaligned;
  logic [31:0] instret;

  // Second instance for the top-of-address-space wrap case.
  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [6:0]  w_opcode;
  logic [2:0]  w_fun3;
  logic        w_fun7;
  logic        w_mis;
  logic [31:0] w_instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .target(target),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .misaligned(misaligned), .instret(instret)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(32'h0000_0013),
    .stall(1'b0), .redirect(1'b0), .target(32'h0000_0000),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .instr(w_instr), .instr_valid(w_valid),
    .opcode(w_opcode), .fun3(w_fun3), .fun7(w_fun7),
    .misaligned(w_mis), .instret(w_instret)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        red;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_vld;
    logic        e_mis;
    logic [31:0] e_pc;
    logic [31:0] e_ret;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SUB  = 32'h4020_8033;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  function automatic vec_t mk(input logic rdy, input logic [31:0] rdata,
                              input logic stl, input logic red,
                              input logic [31:0] tgt, input logic e_req,
                              input logic e_vld, input logic e_mis,
                              input logic [31:0] e_pc, input logic [31:0] e_ret);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.red = red; v.tgt = tgt;
    v.e_req = e_req; v.e_vld = e_vld; v.e_mis = e_mis;
    v.e_pc = e_pc; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata,
                       input logic stl, input logic red, input logic [31:0] tgt);
    imem_ready = rdy; imem_rdata = rdata;
    stall = stl; redirect = red; target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ei;
    rst = 1'b1; w_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Pipeline-free sequence of {inputs, expected} rows; each row is checked
    // after a clock edge and its inputs act at the following edge.
    tbl.push_back(mk(1, NOP,  0, 0, 32'h000, 1, 0, 0, 32'h000, 0));
    tbl.push_back(mk(1, JUNK, 0, 0, 32'h000, 0, 1, 0, 32'h000, 0));
    tbl.push_back(mk(1, ADDI, 0, 0, 32'h000, 1, 0, 0, 32'h004, 1));
    tbl.push_back(mk(0, 0,    0, 0, 32'h000, 0, 1, 0, 32'h004, 1));
    tbl.push_back(mk(0, 0,    0, 0, 32'h000, 1, 0, 0, 32'h008, 2));
    tbl.push_back(mk(0, 0,    1, 1, 32'h040, 1, 0, 0, 32'h008, 2));
    tbl.push_back(mk(1, SUB,  0, 0, 32'h000, 1, 0, 0, 32'h008, 2));
    tbl.push_back(mk(0, 0,    0, 0, 32'h000, 0, 1, 0, 32'h008, 2));
    tbl.push_back(mk(1, ONES, 0, 0, 32'h000, 1, 0, 0, 32'h00C, 3));
    tbl.push_back(mk(0, 0,    0, 0, 32'h000, 0, 1, 0, 32'h00C, 3));
    tbl.push_back(mk(1, NOP,  0, 0, 32'h000, 1, 0, 0, 32'h010, 4));
    tbl.push_back(mk(0, 0,    1, 1, 32'h040, 0, 1, 0, 32'h010, 4));
    tbl.push_back(mk(1, JUNK, 1, 1, 32'h040, 0, 1, 0, 32'h010, 4));
    tbl.push_back(mk(0, 0,    1, 1, 32'h040, 0, 1, 0, 32'h010, 4));
    tbl.push_back(mk(0, 0,    0, 0, 32'h000, 0, 1, 0, 32'h010, 4));
    tbl.push_back(mk(1, ADDI, 0, 0, 32'h000, 1, 0, 0, 32'h014, 5));
    tbl.push_back(mk(0, 0,    0, 1, 32'h020, 0, 1, 0, 32'h014, 5));
    tbl.push_back(mk(1, SUB,  0, 0, 32'h000, 1, 0, 0, 32'h020, 6));
    tbl.push_back(mk(0, 0,    0, 1, 32'h100, 0, 1, 0, 32'h020, 6));
    tbl.push_back(mk(1, NOP,  0, 0, 32'h000, 1, 0, 0, 32'h100, 7));
    tbl.push_back(mk(0, 0,    0, 1, 32'h102, 0, 1, 0, 32'h100, 7));
    tbl.push_back(mk(1, JUNK, 0, 1, 32'h000, 0, 0, 1, 32'h100, 7));

    // Reset state
    tick(); tick();
    chk("rst_req",      {31'd0, imem_req},    32'd0);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_pc",       pc,                   32'h0);
    chk("rst_pc_plus4", pc_plus4,             32'h4);
    chk("rst_instr",    instr,                32'h0);
    chk("rst_opcode",   {25'd0, opcode},      32'd0);
    chk("rst_fun3",     {29'd0, fun3},        32'd0);
    chk("rst_fun7",     {31'd0, fun7},        32'd0);
    chk("rst_instret",  instret,              32'd0);
    chk("rst_mis",      {31'd0, misaligned},  32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      chk($sformatf("r%0d_req", i),   {31'd0, imem_req},    {31'd0, v.e_req});
      chk($sformatf("r%0d_valid", i), {31'd0, instr_valid}, {31'd0, v.e_vld});
      chk($sformatf("r%0d_mis", i),   {31'd0, misaligned},  {31'd0, v.e_mis});
      chk($sformatf("r%0d_pc", i),    pc,                   v.e_pc);
      chk($sformatf("r%0d_addr", i),  imem_addr,            v.e_pc);
      chk($sformatf("r%0d_pc4", i),   pc_plus4,             v.e_pc + 32'd4);
      chk($sformatf("r%0d_ret", i),   instret,              v.e_ret);
      if (instr_valid) begin
        if (sbq.size() == 0) begin
          chk($sformatf("r%0d_sb_empty", i), 32'd0, 32'd1);
        end else begin
          ei = sbq[0].instr;
          chk($sformatf("r%0d_sb_instr", i), instr, ei);
          chk($sformatf("r%0d_sb_pc", i), pc, sbq[0].pc);
          chk($sformatf("r%0d_opcode", i), {25'd0, opcode}, {25'd0, ei[6:0]});
          chk($sformatf("r%0d_fun3", i), {29'd0, fun3}, {29'd0, ei[14:12]});
          chk($sformatf("r%0d_fun7", i), {31'd0, fun7}, {31'd0, ei[30]});
          if (!v.stl) void'(sbq.pop_front());
        end
      end
      if (v.e_req && v.rdy) begin
        sb_t e;
        e.pc = v.e_pc; e.instr = v.rdata;
        sbq.push_back(e);
      end
      drive(v.rdy, v.rdata, v.stl, v.red, v.tgt);
      tick();
    end
    chk("sb_drained", sbq.size(), 32'd0);

    // HALT is absorbing regardless of inputs
    for (int k = 0; k < 10; k++) begin
      chk("halt_req",   {31'd0, imem_req},    32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_mis",   {31'd0, misaligned},  32'd1);
      chk("halt_pc",    pc,                   32'h100);
      chk("halt_ret",   instret,              32'd7);
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            1'b1, 32'h0000_0040);
      tick();
    end

    // Reset out of HALT
    rst = 1'b1;
    tick();
    chk("hrst_mis", {31'd0, misaligned}, 32'd0);
    chk("hrst_pc",  pc,                  32'h0);
    chk("hrst_req", {31'd0, imem_req},   32'd0);
    chk("hrst_ret", instret,             32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("hrst_fetch", {31'd0, imem_req}, 32'd1);

    // Reset wins over a response arriving in the same FETCH cycle
    drive(1'b1, JUNK, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    chk("frst_instr",  instr,                 32'h0);
    chk("frst_req",    {31'd0, imem_req},     32'd0);
    chk("frst_valid",  {31'd0, instr_valid},  32'd0);
    chk("frst_pc",     pc,                    32'h0);
    chk("frst_opcode", {25'd0, opcode},       32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("frst_idle_one", {31'd0, imem_req}, 32'd1);
    chk("frst_instr2",   instr,             32'h0);

    // Sequential flow wrapping past the top of the address space
    w_rst = 1'b1;
    tick();
    chk("wrap_rst_pc",  w_pc,       32'hFFFF_FFFC);
    chk("wrap_rst_pc4", w_pc_plus4, 32'h0000_0000);
    w_rst = 1'b0;
    tick();
    chk("wrap_fetch_req",  {31'd0, w_req}, 32'd1);
    chk("wrap_fetch_addr", w_addr,         32'hFFFF_FFFC);
    tick();
    chk("wrap_issue_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_issue_instr", w_instr,          NOP);
    tick();
    chk("wrap_next_pc",  w_pc,             32'h0000_0000);
    chk("wrap_next_req", {31'd0, w_req},   32'd1);
    chk("wrap_instret",  w_instret,        32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
